// File: rtl/fifo_rd_streamer.sv
// Streams words out of a synchronous FIFO into a valid/ready beat interface with a
// 2-entry skid buffer and m_last every BURST beats. Optional FIFO_RD_STREAMER_CNT_EN adds total_beats.
//
// state | meaning
// IDLE  | no reads issued, waiting for en
// RUN   | issuing FIFO reads while there is room and data
// STOP  | en dropped; draining in-flight and buffered beats
module fifo_rd_streamer #(
    parameter int DWIDTH = 16,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
`ifdef FIFO_RD_STREAMER_CNT_EN
    output logic [15:0]       total_beats,
`endif
    output logic              busy
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t            state;
    logic [1:0]        occ;
    logic              inflight;
    logic [DWIDTH-1:0] buf1;
    logic [CW-1:0]     cnt;

    logic              pop;
    logic [2:0]        pending;
    logic [1:0]        occ_nxt;
    logic [CW-1:0]     cnt_nxt;

    // pending is the occupancy the buffer will have once the current read lands
    assign pop        = m_valid & m_ready;
    assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign occ_nxt    = pending[1:0];
    assign fifo_rd_en = rstn & (state == RUN) & en & ~fifo_empty & (pending < 3'd2);
    assign cnt_nxt    = pop ? ((cnt == LAST_CNT) ? '0 : cnt + CW'(1)) : cnt;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            cnt      <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            buf1     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ_nxt;
            cnt      <= cnt_nxt;
            m_valid  <= (occ_nxt != 2'd0);
            m_last   <= (occ_nxt != 2'd0) && (cnt_nxt == LAST_CNT);

            // m_data is the head entry, buf1 the second entry
            if (pop) begin
                if (inflight && occ == 2'd1)
                    m_data <= fifo_dout;
                else
                    m_data <= buf1;
                if (inflight && occ == 2'd2)
                    buf1 <= fifo_dout;
            end else if (inflight) begin
                if (occ == 2'd0)
                    m_data <= fifo_dout;
                else
                    buf1 <= fifo_dout;
            end

            case (state)
                IDLE: if (en) state <= RUN;
                RUN:  if (!en) state <= STOP;
                STOP: begin
                    if (en)
                        state <= RUN;
                    else if (!inflight && occ == 2'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_RD_STREAMER_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            total_beats <= 16'd0;
        else if (pop && total_beats != 16'hFFFF)
            total_beats <= total_beats + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Testbench for fifo_rd_streamer: behavioural synchronous FIFO, per-beat scoreboard,
// a cycle table for the nominal stream and hand sequences for stall, empty, en-drop and reset.
module tb_fifo_rd_streamer;
    localparam int DW    = 16;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
`ifdef FIFO_RD_STREAMER_CNT_EN
    logic [15:0]   total_beats;
`endif

    fifo_rd_streamer #(.DWIDTH(DW), .BURST(BURST)) dut (
        .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
`ifdef FIFO_RD_STREAMER_CNT_EN
        .total_beats(total_beats),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // synchronous FIFO model: data appears the cycle after a read
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q [$];
    int reads = 0, pops = 0, beat_idx = 0, delivered = 0;
    logic held_v = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic held_l = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    task automatic sample();
        logic pop;
        logic [DW-1:0] e;
        pop = m_valid & m_ready;
        if (fifo_rd_en) begin
            chk("rd_en_while_empty", fifo_empty, 0);
            chk("rd_en_no_room", ((reads - pops - int'(pop)) < 2), 1);
        end
        if (held_v) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, held_d);
            chk("stall_last", m_last, held_l);
        end
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", m_data, 32'hDEAD_BEEF);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", m_data, e);
                chk("beat_last", m_last, ((beat_idx % BURST) == BURST - 1));
                beat_idx++;
                delivered++;
            end
        end
        held_v = m_valid & ~m_ready;
        held_d = m_data;
        held_l = m_last;
        reads += int'(fifo_rd_en);
        pops  += int'(pop);
    endtask

    task automatic tick(input logic e, input logic r, input int pw);
        @(negedge clk);
        en = e;
        m_ready = r;
        if (pw >= 0) push(pw[DW-1:0]);
        #1;
        sample();
    endtask

    task automatic do_reset(input logic e, input logic r);
        @(negedge clk);
        rstn = 1'b0;
        en = e;
        m_ready = r;
        #1;
        chk("rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
`ifdef FIFO_RD_STREAMER_CNT_EN
        chk("rst_total", total_beats, 0);
`endif
        rstn = 1'b1;
        en = 1'b0;
        m_ready = 1'b0;
        reads = 0; pops = 0; beat_idx = 0; held_v = 1'b0;
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          rd_en;
        logic          valid;
        logic          last;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [12];
    logic [DW-1:0] dropped;

    initial begin
        // nominal stream of 8 preloaded words with m_ready held high
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0002};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0003};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0004};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0005};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0006};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0007};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0008};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};

        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) push(DW'(i));
        for (int i = 0; i < 12; i++) begin
            tick(tbl[i].en, tbl[i].rdy, -1);
            chk($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].rd_en);
            chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_last", i), m_last, tbl[i].last);
            if (tbl[i].valid) chk($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
        end

        // m_ready toggling every cycle
        do_reset(1'b0, 1'b0);
        delivered = 0;
        for (int i = 1; i <= 8; i++) push(DW'(i));
        for (int i = 0; i < 30; i++) tick(1'b1, logic'(i % 2 == 0), -1);
        chk("toggle_delivered", delivered, 8);
        chk("toggle_left", exp_q.size(), 0);

        // FIFO runs dry after 3 words, then a 4th arrives
        do_reset(1'b0, 1'b0);
        delivered = 0;
        push(16'h0011); push(16'h0012); push(16'h0013);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, -1);
        chk("dry_delivered", delivered, 3);
        chk("dry_rd_en", fifo_rd_en, 0);
        chk("dry_empty", fifo_empty, 1);
        chk("dry_busy", busy, 1);
        tick(1'b1, 1'b1, 16'h0014);
        chk("dry_resume_rd_en", fifo_rd_en, 1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, -1);
        chk("dry_delivered4", delivered, 4);

        // en dropped after the second read, then restarted
        do_reset(1'b0, 1'b0);
        delivered = 0;
        for (int i = 1; i <= 8; i++) push(DW'(16'h0020 + i));
        tick(1'b1, 1'b1, -1);
        chk("stop_c0_busy", busy, 0);
        tick(1'b1, 1'b1, -1);
        chk("stop_c1_rd_en", fifo_rd_en, 1);
        tick(1'b1, 1'b1, -1);
        chk("stop_c2_rd_en", fifo_rd_en, 1);
        tick(1'b0, 1'b1, -1);
        chk("stop_c3_rd_en", fifo_rd_en, 0);
        chk("stop_c3_valid", m_valid, 1);
        chk("stop_c3_busy", busy, 1);
        tick(1'b0, 1'b1, -1);
        chk("stop_c4_valid", m_valid, 1);
        chk("stop_c4_busy", busy, 1);
        tick(1'b0, 1'b1, -1);
        chk("stop_c5_valid", m_valid, 0);
        chk("stop_c5_busy", busy, 1);
        tick(1'b0, 1'b1, -1);
        chk("stop_c6_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, -1);
            chk("stop_idle_rd_en", fifo_rd_en, 0);
        end
        chk("stop_delivered", delivered, 2);
        for (int i = 0; i < 14; i++) tick(1'b1, 1'b1, -1);
        chk("restart_delivered", delivered, 8);

        // reset with one beat buffered and one read in flight
        do_reset(1'b0, 1'b0);
        delivered = 0;
        for (int i = 1; i <= 8; i++) push(DW'(16'h0030 + i));
        tick(1'b1, 1'b0, -1);
        tick(1'b1, 1'b0, -1);
        chk("rstmid_c1_rd_en", fifo_rd_en, 1);
        tick(1'b1, 1'b0, -1);
        chk("rstmid_c2_rd_en", fifo_rd_en, 1);
        do_reset(1'b1, 1'b1);
        dropped = exp_q.pop_front();
        dropped = exp_q.pop_front();
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, -1);
        chk("rstmid_delivered", delivered, 6);
        chk("rstmid_left", exp_q.size(), 0);

`ifdef FIFO_RD_STREAMER_CNT_EN
        do_reset(1'b0, 1'b0);
        begin
            int pushed;
            pushed = 0;
            for (int i = 0; i < 70010; i++) begin
                if ((wr_ptr - rd_ptr) < 100 && pushed < 70000) begin
                    tick(1'b1, 1'b1, pushed & 16'hFFFF);
                    pushed++;
                end else begin
                    tick(1'b1, 1'b1, -1);
                end
            end
        end
        chk("total_beats_sat", total_beats, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
